// File: rtl/md_unit_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | md_unit_ctrl : mult/div sequencer owning HI/LO, busy counter, D stall   |
// | Optional accumulate ops (madd/maddu/msub/msubu) under MDU_MADD_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start_E,
  input  logic [3:0]  MDOp_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  input  logic        MDUse_D,
  output logic        Busy,
  output logic        Stall_D,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int C_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W        = $clog2(C_MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] C_OP_MULT  = 4'd1;
  localparam logic [3:0] C_OP_MULTU = 4'd2;
  localparam logic [3:0] C_OP_DIV   = 4'd3;
  localparam logic [3:0] C_OP_DIVU  = 4'd4;
  localparam logic [3:0] C_OP_MTHI  = 4'd5;
  localparam logic [3:0] C_OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] C_OP_MADD  = 4'd7;
  localparam logic [3:0] C_OP_MADDU = 4'd8;
  localparam logic [3:0] C_OP_MSUB  = 4'd9;
  localparam logic [3:0] C_OP_MSUBU = 4'd10;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      shadow_q, shadow_d;

  logic [63:0] w_a_sx, w_b_sx;
  logic [63:0] w_prod_s, w_prod_u;
  logic [63:0] w_hilo;
  logic        w_div_zero;
  logic [31:0] w_divisor_u, w_quot_u, w_rem_u;
  logic [31:0] w_a_mag, w_b_mag, w_b_mag_nz;
  logic [31:0] w_quot_mag, w_rem_mag, w_quot_s, w_rem_s;

  assign w_a_sx   = {{32{A_E[31]}}, A_E};
  assign w_b_sx   = {{32{B_E[31]}}, B_E};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, A_E} * {32'd0, B_E};
  assign w_hilo   = {hi_q, lo_q};

  // Divisor is forced non-zero so the dividers never see 0; a zero divide
  // commits the current HI/LO instead of the quotient.
  assign w_div_zero  = (B_E == 32'd0);
  assign w_divisor_u = w_div_zero ? 32'd1 : B_E;
  assign w_quot_u    = A_E / w_divisor_u;
  assign w_rem_u     = A_E % w_divisor_u;

  // Signed divide on magnitudes: truncation toward zero, remainder follows dividend.
  assign w_a_mag    = A_E[31] ? (32'd0 - A_E) : A_E;
  assign w_b_mag    = B_E[31] ? (32'd0 - B_E) : B_E;
  assign w_b_mag_nz = w_div_zero ? 32'd1 : w_b_mag;
  assign w_quot_mag = w_a_mag / w_b_mag_nz;
  assign w_rem_mag  = w_a_mag % w_b_mag_nz;
  assign w_quot_s   = (A_E[31] ^ B_E[31]) ? (32'd0 - w_quot_mag) : w_quot_mag;
  assign w_rem_s    = A_E[31] ? (32'd0 - w_rem_mag) : w_rem_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (Start_E) begin
          case (MDOp_E)
            C_OP_MULT: begin
              shadow_d = w_prod_s;
              cnt_d    = C_MULT_CNT;
              state_d  = ST_RUN;
            end
            C_OP_MULTU: begin
              shadow_d = w_prod_u;
              cnt_d    = C_MULT_CNT;
              state_d  = ST_RUN;
            end
            C_OP_DIV: begin
              shadow_d = w_div_zero ? w_hilo : {w_rem_s, w_quot_s};
              cnt_d    = C_DIV_CNT;
              state_d  = ST_RUN;
            end
            C_OP_DIVU: begin
              shadow_d = w_div_zero ? w_hilo : {w_rem_u, w_quot_u};
              cnt_d    = C_DIV_CNT;
              state_d  = ST_RUN;
            end
            C_OP_MTHI: hi_d = A_E;
            C_OP_MTLO: lo_d = A_E;
`ifdef MDU_MADD_EN
            C_OP_MADD: begin
              shadow_d = w_hilo + w_prod_s;
              cnt_d    = C_MULT_CNT;
              state_d  = ST_RUN;
            end
            C_OP_MADDU: begin
              shadow_d = w_hilo + w_prod_u;
              cnt_d    = C_MULT_CNT;
              state_d  = ST_RUN;
            end
            C_OP_MSUB: begin
              shadow_d = w_hilo - w_prod_s;
              cnt_d    = C_MULT_CNT;
              state_d  = ST_RUN;
            end
            C_OP_MSUBU: begin
              shadow_d = w_hilo - w_prod_u;
              cnt_d    = C_MULT_CNT;
              state_d  = ST_RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // New starts are ignored here; the pipeline is already stalled.
        if (cnt_q <= C_CNT_ONE) begin
          hi_d    = shadow_q[63:32];
          lo_d    = shadow_q[31:0];
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      shadow_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      shadow_q <= shadow_d;
    end
  end

  assign Busy    = busy_q;
  assign HI      = hi_q;
  assign LO      = lo_q;
  assign Stall_D = MDUse_D & (busy_q | Start_E);

endmodule
`default_nettype wire

// File: tb/tb_md_unit_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_md_unit_ctrl : scoreboard bench for md_unit_ctrl (directed + random) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_md_unit_ctrl;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start_E;
  logic [3:0]  MDOp_E;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic        MDUse_D;
  logic        Busy;
  logic        Stall_D;
  logic [31:0] HI;
  logic [31:0] LO;

  md_unit_ctrl #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .Start_E(Start_E),
    .MDOp_E (MDOp_E),
    .A_E    (A_E),
    .B_E    (B_E),
    .MDUse_D(MDUse_D),
    .Busy   (Busy),
    .Stall_D(Stall_D),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_n    = 0;

  // Reference model: architectural HI/LO, pending result, cycles of busy left.
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left  = 0;
  bit          m_known = 1'b0;

  task automatic check(input string name, input logic [31:0] cyc,
                       input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, want);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("busy",  mon_e.cyc, {31'd0, Busy},    {31'd0, mon_e.busy});
      check("stall", mon_e.cyc, {31'd0, Stall_D}, {31'd0, mon_e.stall});
      check("hi",    mon_e.cyc, HI, mon_e.hi);
      check("lo",    mon_e.cyc, LO, mon_e.lo);
    end
  end

  task automatic model_edge(input bit r, input bit s, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    logic [63:0] pu;
    int          sa, sb, q, rm;
    ps = longint'($signed(a)) * longint'($signed(b));
    pu = {32'd0, a} * {32'd0, b};
    if (r) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_pend = 0; m_known = 1'b1;
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (s) begin
      case (op)
        4'd1: begin m_pend = ps; m_left = MULT_CYCLES; end
        4'd2: begin m_pend = pu; m_left = MULT_CYCLES; end
        4'd3: begin
          m_left = DIV_CYCLES;
          sa = $signed(a); sb = $signed(b);
          if (b == 0) m_pend = {m_hi, m_lo};
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) m_pend = {32'd0, 32'h8000_0000};
          else begin
            q = sa / sb; rm = sa % sb;
            m_pend = {rm, q};
          end
        end
        4'd4: begin
          m_left = DIV_CYCLES;
          if (b == 0) m_pend = {m_hi, m_lo};
          else m_pend = {a % b, a / b};
        end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
`ifdef MDU_MADD_EN
        4'd7:  begin m_pend = {m_hi, m_lo} + ps; m_left = MULT_CYCLES; end
        4'd8:  begin m_pend = {m_hi, m_lo} + pu; m_left = MULT_CYCLES; end
        4'd9:  begin m_pend = {m_hi, m_lo} - ps; m_left = MULT_CYCLES; end
        4'd10: begin m_pend = {m_hi, m_lo} - pu; m_left = MULT_CYCLES; end
`endif
        default: ;
      endcase
    end
  endtask

  // One clock cycle: drive inputs, queue the outputs expected during it, advance.
  task automatic step(input bit r, input bit s, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b, input bit u);
    exp_t e;
    reset = r; Start_E = s; MDOp_E = op; A_E = a; B_E = b; MDUse_D = u;
    if (m_known) begin
      e.busy  = (m_left != 0);
      e.stall = u & ((m_left != 0) | s);
      e.hi    = m_hi;
      e.lo    = m_lo;
      e.cyc   = cyc_n;
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_edge(r, s, op, a, b);
    cyc_n++;
    #1;
  endtask

  task automatic idle(input int n, input bit u);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, u);
  endtask

  task automatic op1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit u);
    step(1'b0, 1'b1, op, a, b, u);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    idle(1, 1'b1);

    op1(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0); idle(MULT_CYCLES + 1, 1'b0);
    op1(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0); idle(MULT_CYCLES + 1, 1'b0);
    op1(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0); idle(DIV_CYCLES + 1, 1'b0);
    op1(4'd4, 32'd7, 32'd0, 1'b0);         idle(DIV_CYCLES + 1, 1'b0);
    op1(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); idle(DIV_CYCLES + 1, 1'b0);

    op1(4'd5, 32'h1234_5678, 32'd0, 1'b0);
    op1(4'd6, 32'h9ABC_DEF0, 32'd0, 1'b0);
    idle(2, 1'b0);

    op1(4'd1, 32'd3, 32'hFFFF_FFFE, 1'b1); idle(MULT_CYCLES + 2, 1'b1);
    op1(4'd3, 32'd100, 32'd7, 1'b0);
    idle(2, 1'b1);
    op1(4'd1, 32'd9, 32'd9, 1'b1);
    op1(4'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);
    idle(DIV_CYCLES, 1'b0);

    op1(4'd4, 32'd1000, 32'd3, 1'b0);
    idle(4, 1'b0);
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    idle(2, 1'b1);

    op1(4'd5, 32'd0, 32'd0, 1'b0);
    op1(4'd6, 32'd5, 32'd0, 1'b0);
    op1(4'd7, 32'hFFFF_FFFF, 32'd3, 1'b0); idle(MULT_CYCLES + 1, 1'b0);
    op1(4'd10, 32'd1, 32'd3, 1'b0);        idle(MULT_CYCLES + 1, 1'b0);
    op1(4'd11, 32'd1, 32'd3, 1'b1);        idle(1, 1'b0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
           4'($urandom_range(0, 15)), rnd_val(), rnd_val(),
           ($urandom_range(0, 1) == 1));
    end
    idle(DIV_CYCLES + 2, 1'b0);

    @(negedge clk);
    #1;
    check("drain", cyc_n, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
